// File: rtl/gfx256_pkg.sv
// rtl/gfx256_pkg.sv - shared state encoding, requester indices and helpers for the gfx256 Wishbone arbiter
package gfx256_pkg;

    localparam logic [0:0] GFX256_ST_IDLE  = 1'b0;
    localparam logic [0:0] GFX256_ST_GRANT = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = GFX256_ST_IDLE,
        GRANT = GFX256_ST_GRANT
    } gfx256_arb_state_t;

    localparam int GFX256_REQ_WRITER   = 0;
    localparam int GFX256_REQ_CLIP     = 1;
    localparam int GFX256_REQ_FRAGMENT = 2;
    localparam int GFX256_REQ_BLENDER  = 3;
    localparam int GFX256_REQ_TEXTBLIT = 4;

    // Round-robin successor of a requester index, wrapping the last requester back to 0.
    function automatic logic [2:0] gfx256_next_idx(input logic [2:0] idx, input int nreq);
        return (int'(idx) >= nreq - 1) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/gfx256_wbm_rr_arbiter_if.sv
// rtl/gfx256_wbm_rr_arbiter_if.sv - requester-side and wbm-side bus bundle of the gfx256 arbiter
interface gfx256_wbm_rr_arbiter_if #(
    parameter int WID  = 256,
    parameter int NREQ = 5
);
    logic [NREQ-1:0]                rreq_i;
    logic [NREQ-1:0]                wreq_i;
    logic [NREQ-1:0][31:0]          maddr_i;
    logic [NREQ-1:0][WID/8-1:0]     msel_i;
    logic [NREQ-1:0][WID-1:0]       mdat_i;
    logic [NREQ-1:0]                mack_o;
    logic [WID-1:0]                 mdat_o;
    logic                           read_request_o;
    logic                           write_request_o;
    logic [31:0]                    addr_o;
    logic [WID/8-1:0]               sel_o;
    logic                           we_o;
    logic [WID-1:0]                 dat_o;
    logic [WID-1:0]                 dat_i;
    logic                           ack_i;
    logic                           busy_o;
    logic [2:0]                     grant_o;
    logic                           timeout_o;
    logic                           timeout_clr_i;

    // Arbiter side.
    modport master (
        input  rreq_i, wreq_i, maddr_i, msel_i, mdat_i, dat_i, ack_i, timeout_clr_i,
        output mack_o, mdat_o, read_request_o, write_request_o, addr_o, sel_o, we_o,
        output dat_o, busy_o, grant_o, timeout_o
    );

    // Requesters plus the wbm reader/writer.
    modport slave (
        output rreq_i, wreq_i, maddr_i, msel_i, mdat_i, dat_i, ack_i, timeout_clr_i,
        input  mack_o, mdat_o, read_request_o, write_request_o, addr_o, sel_o, we_o,
        input  dat_o, busy_o, grant_o, timeout_o
    );
endinterface

// File: rtl/gfx256_rr_pick.sv
// rtl/gfx256_rr_pick.sv - combinational round-robin pick of the first eligible requester at or after ptr
module gfx256_rr_pick #(
    parameter int NREQ = 5
) (
    input  logic [NREQ-1:0] pend_i,
    input  logic [2:0]      ptr_i,
    input  logic [NREQ-1:0] mask_i,
    output logic [2:0]      idx_o,
    output logic            valid_o
);

    // Scan from the farthest offset down so the offset closest to ptr wins last.
    always_comb begin
        logic [NREQ-1:0] elig;
        int              j;
        elig    = pend_i & ~mask_i;
        idx_o   = 3'd0;
        valid_o = 1'b0;
        j       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (elig[j]) begin
                idx_o   = 3'(j);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gfx256_wbm_rr_arbiter.sv
// rtl/gfx256_wbm_rr_arbiter.sv - registered round-robin Wishbone master arbiter; watchdog under GFX256_ARB_TIMEOUT_EN
module gfx256_wbm_rr_arbiter
    import gfx256_pkg::*;
#(
    parameter int WID     = 256,
    parameter int NREQ    = 5,
    parameter int TIMEOUT = 1023
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    gfx256_wbm_rr_arbiter_if.master       bus
);

    gfx256_arb_state_t  state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [2:0]         grant_q, grant_d;
    logic [NREQ-1:0]    mask_q, mask_d;
    logic               rreq_q, rreq_d;
    logic               wreq_q, wreq_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [WID/8-1:0]   sel_q, sel_d;
    logic [WID-1:0]     dat_q, dat_d;

    logic [NREQ-1:0]    pend;
    logic [NREQ-1:0]    grant_oh;
    logic [2:0]         pick_idx;
    logic               pick_vld;
    logic               fire;
    logic               done;

    assign pend     = bus.rreq_i | bus.wreq_i;
    assign grant_oh = NREQ'(1) << grant_q;
    assign done     = (state_q == GRANT) && (bus.ack_i || fire);

    gfx256_rr_pick #(.NREQ(NREQ)) u_pick (
        .pend_i  (pend),
        .ptr_i   (ptr_q),
        .mask_i  (mask_q),
        .idx_o   (pick_idx),
        .valid_o (pick_vld)
    );

`ifdef GFX256_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;

    assign fire = (state_q == GRANT) && !bus.ack_i && (cnt_q == 16'(TIMEOUT - 1));

    // Watchdog: count un-acked GRANT cycles; the sticky flag's set beats its clear.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (state_q == IDLE) begin
            cnt_d = 16'd0;
        end else if (!bus.ack_i) begin
            cnt_d = cnt_q + 16'd1;
        end
        if (fire) begin
            timeout_d = 1'b1;
        end else if (bus.timeout_clr_i) begin
            timeout_d = 1'b0;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q     <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    logic unused_cfg;
    assign unused_cfg    = ^{bus.timeout_clr_i, 16'(TIMEOUT)};
    assign fire          = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    // Arbitration FSM: latch the winner's fields in IDLE, hold them until ack or watchdog.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        mask_d  = '0;
        rreq_d  = rreq_q;
        wreq_d  = wreq_q;
        we_d    = we_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    addr_d  = bus.maddr_i[pick_idx];
                    sel_d   = bus.msel_i[pick_idx];
                    dat_d   = bus.mdat_i[pick_idx];
                    we_d    = bus.wreq_i[pick_idx];
                    wreq_d  = bus.wreq_i[pick_idx];
                    rreq_d  = !bus.wreq_i[pick_idx];
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (done) begin
                    rreq_d  = 1'b0;
                    wreq_d  = 1'b0;
                    ptr_d   = gfx256_next_idx(grant_q, NREQ);
                    // A registered request drop lags the ack by a cycle; masking avoids a duplicate.
                    mask_d  = grant_oh;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbitration registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            grant_q <= 3'd0;
            mask_q  <= '0;
            rreq_q  <= 1'b0;
            wreq_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            mask_q  <= mask_d;
            rreq_q  <= rreq_d;
            wreq_q  <= wreq_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
        end
    end

    assign bus.mack_o          = done ? grant_oh : '0;
    assign bus.mdat_o          = bus.dat_i;
    assign bus.read_request_o  = rreq_q;
    assign bus.write_request_o = wreq_q;
    assign bus.addr_o          = addr_q;
    assign bus.sel_o           = sel_q;
    assign bus.we_o            = we_q;
    assign bus.dat_o           = dat_q;
    assign bus.grant_o         = grant_q;
    assign bus.busy_o          = (|pend) || (state_q == GRANT);

endmodule
